cpu_debug_jtag_driver: RTL and testbench
========================================

# cpu_debug_jtag_driver

Initiator side of the CPU debug slave's virtual-JTAG link: accepts a (2-bit IR, 38-bit DR) command on a valid/ready port and plays the matching UIR → CDR → SDR → UDR sequence onto the vji_* signals that the debug slave's TCK-domain logic consumes. Returns the 38-bit word shifted out of the slave on vji_tdo. Used as the on-chip debug master in place of the sld_virtual_jtag_basic hub, and as the bus-functional driver in simulation.

## Interface
- SR_WIDTH, 38, DR shift length; must equal the slave's sr width.
- IR_WIDTH, 2, virtual IR width.
- TCK_DIV, 2, clk cycles per vji_tck half-period; legal range 1..255.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; one clock, reset asynchronous active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_ir  in  IR_WIDTH  IR value for this transaction.
- cmd_data  in  SR_WIDTH  DR value shifted in, LSB first.
- rsp_valid  out  1  one-clk pulse; transaction complete.
- rsp_data  out  SR_WIDTH  captured tdo bits; held until next rsp_valid.
- vji_tck  out  1  generated TCK; low when idle.
- vji_tdi  out  1  serial data to slave.
- vji_tdo  in  1  serial data from slave.
- vji_ir_in  out  IR_WIDTH  IR presented to slave.
- vji_ir_out  in  IR_WIDTH  slave IR readback (unused except in the IR-cache check).
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1  virtual TAP state strobes.

## Operation
- States: IDLE, UIR, CDR, SDR, UDR, DONE.
- IDLE: vji_rti=1, tck held low, cmd_ready=1. On cmd_valid&&cmd_ready latch cmd_ir/cmd_data, go UIR.
- Each of UIR, CDR, UDR lasts exactly one TCK period; SDR lasts SR_WIDTH TCK periods. A TCK period = TCK_DIV clks low, then TCK_DIV clks high. State strobes change only at the clk where tck falls (or leaves IDLE).
- UIR: vji_uir=1, vji_ir_in=latched IR. vji_ir_in holds its value until next UIR.
- CDR: vji_cdr=1; slave captures its status into sr on the rising TCK.
- SDR: vji_sdr=1; vji_tdi = tx[0]. On the clk where tck rises, sample vji_tdo into rx MSB (rx shifts right) and shift tx right. After SR_WIDTH rising edges rx holds slave sr bit0..bitN-1 in rsp_data[0..N-1].
- UDR: vji_udr=1 for one TCK period; slave's sysclk side decodes take_action_*.
- DONE: one clk; rsp_valid=1, rsp_data=rx; return IDLE, cmd_ready=1 next clk.
- Bit counter width clog2(SR_WIDTH+1); divider counter width 8.

## Timing
- Reset values: all vji_* strobes 0 except vji_rti=1; vji_tck=0, vji_tdi=0, vji_ir_in=0, cmd_ready=1, rsp_valid=0, rsp_data=0, IR cache invalid.
- Latency: accept at edge E0; rsp_valid high during the clk after E0 + (SR_WIDTH+3)·2·TCK_DIV edges (defaults: 164 clks, pulse on clk 165).
- cmd_valid during non-IDLE ignored; no queuing.
- Reset asserted mid-transaction: immediate return to IDLE, tck low, no rsp_valid; partially shifted data discarded.
- tdo sampled on the clk edge at which vji_tck transitions 0→1 (value valid from prior falling edge).

## Configuration
- CPU_DEBUG_DRV_IR_CACHE_EN: defined → driver remembers last IR sent; if cmd_ir equals cached IR and cache valid, UIR state skipped (latency drops by 2·TCK_DIV). Cache invalidated by reset. Undefined → UIR always issued; latency fixed as above.

## Structure
- Package cpu_debug_pkg: state enum, IR code constants (OCIMEM=2'b00, TRACEMEM=2'b01, BREAK=2'b10, TRACECTRL=2'b11), SR_WIDTH default.
- Sub-module cpu_debug_tck_gen: TCK_DIV divider producing vji_tck plus one-clk rise_en/fall_en strobes; enabled only outside IDLE.

## Test plan
- Reset release, no command → vji_rti=1, vji_tck=0, cmd_ready=1, all other outputs 0 for 100 clks.
- cmd_ir=2'b10, cmd_data=38'h2A_5A5A_5A5A, loopback model (tdo=slave sr[0], slave capture 38'h15_1234_5678) → tdi stream equals cmd_data LSB first; rsp_data=38'h15_1234_5678; rsp_valid at clk 165.
- TCK_DIV=1, back-to-back commands with cmd_valid held → second accept exactly 1 clk after first rsp_valid; each rsp correct.
- Reset asserted at SDR bit 17 → next clk IDLE, tck=0, no rsp_valid; following command completes normally.
- With CPU_DEBUG_DRV_IR_CACHE_EN, two commands ir=2'b00 → second has no vji_uir pulse, latency 160 clks; third with ir=2'b01 issues UIR.
- cmd_valid pulsed mid-transaction → ignored; exactly one rsp_valid per accepted command.

Source files
------------

// File: rtl/cpu_debug_pkg.sv
// Shared state encoding, virtual-TAP strobe bundle and IR codes for the CPU debug JTAG driver.
package cpu_debug_pkg;

  localparam int SR_WIDTH_DEF = 38;
  localparam int IR_WIDTH_DEF = 2;

  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACEMEM  = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_DONE
  } drv_state_e;

  typedef struct packed {
    logic rti;
    logic uir;
    logic cdr;
    logic sdr;
    logic udr;
  } vtap_t;

  // Strobe pattern the slave must see while the driver sits in a given state.
  function automatic vtap_t vtap_of(drv_state_e st);
    vtap_t v;
    v = '0;
    case (st)
      ST_IDLE: v.rti = 1'b1;
      ST_UIR:  v.uir = 1'b1;
      ST_CDR:  v.cdr = 1'b1;
      ST_SDR:  v.sdr = 1'b1;
      ST_UDR:  v.udr = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cpu_debug_tck_gen.sv
// TCK generator: TCK_DIV clks low then TCK_DIV clks high while en, held low otherwise (TCK_DIV 1..255).
// rise_en/fall_en are high in the clk before the edge at which tck rises/falls.
module cpu_debug_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic rise_en,
  output logic fall_en
);

  localparam logic [7:0] DIV_LAST = 8'(TCK_DIV - 1);

  logic [7:0] div_cnt;
  logic       at_last;

  assign at_last = en && (div_cnt == DIV_LAST);
  assign rise_en = at_last && !tck;
  assign fall_en = at_last && tck;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      tck     <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      tck     <= 1'b0;
    end else if (at_last) begin
      div_cnt <= '0;
      tck     <= ~tck;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/cpu_debug_jtag_driver.sv
// Virtual-JTAG initiator: plays UIR/CDR/SDR/UDR for one (IR, DR) command and returns the DR shifted out on vji_tdo.
// Latency: (SR_WIDTH+3)*2*TCK_DIV clks accept to rsp_valid; CPU_DEBUG_DRV_IR_CACHE_EN skips UIR on a repeated IR.
// Backpressure: cmd_ready only in IDLE, cmd_valid elsewhere ignored; rsp_valid is a one-clk pulse with no ready.
module cpu_debug_jtag_driver
  import cpu_debug_pkg::*;
#(
  parameter int SR_WIDTH = SR_WIDTH_DEF,
  parameter int IR_WIDTH = IR_WIDTH_DEF,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int CNT_W = $clog2(SR_WIDTH + 1);

  drv_state_e          state;
  vtap_t               vtap;
  logic [SR_WIDTH-1:0] tx_sr;
  logic [SR_WIDTH-1:0] rx_sr;
  logic [CNT_W-1:0]    bit_cnt;
  logic                tck_en;
  logic                rise_en;
  logic                fall_en;
  logic                ir_hit;

  assign tck_en = (state != ST_IDLE) && (state != ST_DONE);

  cpu_debug_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck_gen (
    .clk     (clk),
    .reset   (reset),
    .en      (tck_en),
    .tck     (vji_tck),
    .rise_en (rise_en),
    .fall_en (fall_en)
  );

`ifdef CPU_DEBUG_DRV_IR_CACHE_EN
  // vji_ir_in doubles as the cache; the slave readback must agree before UIR is skipped.
  logic cache_vld;

  assign ir_hit = cache_vld && (cmd_ir == vji_ir_in) && (vji_ir_out == vji_ir_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_vld <= 1'b0;
    end else if (state == ST_IDLE && cmd_valid && cmd_ready) begin
      cache_vld <= 1'b1;
    end
  end
`else
  logic unused_ir_out;

  assign ir_hit        = 1'b0;
  assign unused_ir_out = ^vji_ir_out;
`endif

  assign vji_rti = vtap.rti;
  assign vji_uir = vtap.uir;
  assign vji_cdr = vtap.cdr;
  assign vji_sdr = vtap.sdr;
  assign vji_udr = vtap.udr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      vtap      <= vtap_of(ST_IDLE);
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      vji_tdi   <= 1'b0;
      vji_ir_in <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            tx_sr     <= cmd_data;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            cmd_ready <= 1'b0;
            if (ir_hit) begin
              state <= ST_CDR;
              vtap  <= vtap_of(ST_CDR);
            end else begin
              vji_ir_in <= cmd_ir;
              state     <= ST_UIR;
              vtap      <= vtap_of(ST_UIR);
            end
          end
        end
        ST_UIR: begin
          if (fall_en) begin
            state <= ST_CDR;
            vtap  <= vtap_of(ST_CDR);
          end
        end
        ST_CDR: begin
          if (fall_en) begin
            state   <= ST_SDR;
            vtap    <= vtap_of(ST_SDR);
            vji_tdi <= tx_sr[0];
          end
        end
        ST_SDR: begin
          // tdi is re-driven on the falling edge so it is stable around the slave's rising-edge sample.
          if (rise_en) begin
            tx_sr   <= {1'b0, tx_sr[SR_WIDTH-1:1]};
            rx_sr   <= {vji_tdo, rx_sr[SR_WIDTH-1:1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
          if (fall_en) begin
            if (bit_cnt == CNT_W'(SR_WIDTH)) begin
              state   <= ST_UDR;
              vtap    <= vtap_of(ST_UDR);
              vji_tdi <= 1'b0;
            end else begin
              vji_tdi <= tx_sr[0];
            end
          end
        end
        ST_UDR: begin
          if (fall_en) begin
            state     <= ST_DONE;
            vtap      <= vtap_of(ST_DONE);
            rsp_valid <= 1'b1;
            rsp_data  <= rx_sr;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          vtap      <= vtap_of(ST_IDLE);
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          vtap      <= vtap_of(ST_IDLE);
          cmd_ready <= 1'b1;
          vji_tdi   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_debug_jtag_driver.sv
// Randomised bench for cpu_debug_jtag_driver: timeline model of the TAP sequence plus a loopback slave.
module tb_cpu_debug_jtag_driver;
  import cpu_debug_pkg::*;

  localparam int SRW = 38;
  localparam int IRW = 2;
  localparam int D   = 2;
  localparam int PER = 2 * D;
`ifdef CPU_DEBUG_DRV_IR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [IRW-1:0] cmd_ir;
  logic [SRW-1:0] cmd_data;
  logic           rsp_valid;
  logic [SRW-1:0] rsp_data;
  logic           vji_tck, vji_tdi, vji_tdo;
  logic [IRW-1:0] vji_ir_in, vji_ir_out;
  logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  cpu_debug_jtag_driver #(
    .SR_WIDTH (SRW),
    .IR_WIDTH (IRW),
    .TCK_DIV  (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ir     (cmd_ir),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .vji_tck    (vji_tck),
    .vji_tdi    (vji_tdi),
    .vji_tdo    (vji_tdo),
    .vji_ir_in  (vji_ir_in),
    .vji_ir_out (vji_ir_out),
    .vji_uir    (vji_uir),
    .vji_cdr    (vji_cdr),
    .vji_sdr    (vji_sdr),
    .vji_udr    (vji_udr),
    .vji_rti    (vji_rti)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // Loopback slave: captures slave_cap-latched word in CDR, shifts tdi in at each SDR rising TCK.
  logic [SRW-1:0] slave_sr = '0;
  logic [SRW-1:0] slave_cap;
  logic [SRW-1:0] m_cap;
  assign vji_tdo    = slave_sr[0];
  assign vji_ir_out = vji_ir_in;

  initial begin
    forever begin
      @(posedge vji_tck);
      if (vji_cdr) slave_sr = m_cap;
      else if (vji_sdr) slave_sr = {vji_tdi, slave_sr[SRW-1:1]};
    end
  end

  // Timeline model: k counts clks since the accept edge; each TAP state owns PER clks.
  bit             m_busy = 1'b0;
  bit             m_uir;
  bit             m_cache_vld = 1'b0;
  int             m_k;
  logic [IRW-1:0] m_ir = '0;
  logic [SRW-1:0] m_data;
  logic [SRW-1:0] m_rsp = '0;
  int n_acc = 0, n_rsp = 0, n_abort = 0, dut_rsp_cnt = 0, uir_cyc = 0;
  int hs_cyc = 0, rsp_cyc = 0;

  logic           e_rti, e_uir, e_cdr, e_sdr, e_udr, e_tck, e_tdi, e_rdy, e_rv;
  logic [IRW-1:0] e_ir;
  logic [SRW-1:0] e_rsp;
  int             total, seg;

  initial begin
    m_cap = '0;
    forever begin
      @(negedge clk);
      e_rti = 1'b1; e_uir = 1'b0; e_cdr = 1'b0; e_sdr = 1'b0; e_udr = 1'b0;
      e_tck = 1'b0; e_tdi = 1'b0; e_rdy = 1'b1; e_rv = 1'b0; e_rsp = m_rsp;
      total = 0;
      if (vji_uir === 1'b1) uir_cyc++;
      if (rsp_valid === 1'b1) dut_rsp_cnt++;
      if (reset) begin
        if (m_busy) n_abort++;
        m_busy = 1'b0; m_ir = '0; m_cache_vld = 1'b0; m_rsp = '0; e_rsp = '0;
      end else if (m_busy) begin
        e_rti = 1'b0; e_rdy = 1'b0;
        total = (m_uir ? SRW + 3 : SRW + 2) * PER;
        if (m_k < total) begin
          seg   = m_k / PER + (m_uir ? 0 : 1);
          e_tck = (m_k % PER) >= D;
          e_uir = (seg == 0);
          e_cdr = (seg == 1);
          e_sdr = (seg >= 2) && (seg <= SRW + 1);
          e_udr = (seg == SRW + 2);
          if (e_sdr) e_tdi = m_data[seg-2];
        end else begin
          e_rv  = 1'b1;
          e_rsp = m_cap;
        end
      end
      e_ir = m_ir;
      chk("cycle", {vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_tck, vji_tdi,
                    cmd_ready, rsp_valid, vji_ir_in, rsp_data},
                   {e_rti, e_uir, e_cdr, e_sdr, e_udr, e_tck, e_tdi, e_rdy, e_rv, e_ir, e_rsp});
      if (!reset && m_busy) begin
        if (m_k == total) begin
          m_busy  = 1'b0;
          m_rsp   = m_cap;
          n_rsp++;
          rsp_cyc = cyc;
          chk("shift_in", slave_sr, m_data);
        end else begin
          m_k++;
        end
      end else if (!reset && cmd_valid === 1'b1) begin
        m_uir = !(CACHE && m_cache_vld && cmd_ir == m_ir);
        if (m_uir) begin
          m_ir        = cmd_ir;
          m_cache_vld = 1'b1;
        end
        m_data = cmd_data;
        m_cap  = slave_cap;
        m_busy = 1'b1;
        m_k    = 0;
        n_acc++;
        hs_cyc = cyc;
      end
    end
  end

  task automatic wait_acc(input int target);
    int b;
    b = 0;
    while (n_acc < target && b < 400) begin
      @(posedge clk);
      b++;
    end
    #1;
    chk("accept_wait", 64'(n_acc >= target), 64'd1);
  endtask

  task automatic send(input logic [IRW-1:0] ir, input logic [SRW-1:0] d, input logic [SRW-1:0] cap);
    int tgt;
    tgt       = n_acc + 1;
    cmd_ir    = ir;
    cmd_data  = d;
    slave_cap = cap;
    cmd_valid = 1'b1;
    wait_acc(tgt);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input bit noise);
    int b;
    b = 0;
    while (n_rsp < target && b < 400) begin
      @(posedge clk);
      #1;
      b++;
      if (noise && m_busy && m_k < 100) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_ir    = IRW'($urandom);
        cmd_data  = SRW'({$urandom, $urandom});
      end else begin
        cmd_valid = 1'b0;
      end
    end
    chk("rsp_wait", 64'(n_rsp >= target), 64'd1);
  endtask

  int             a0, r0, u0;
  logic [SRW-1:0] d1, c1, d2, c2;

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=no finish expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0; slave_cap = '0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rti", 64'(vji_rti), 64'd1);
    chk("rst_tck", 64'(vji_tck), 64'd0);
    chk("rst_rsp", 64'(rsp_data), 64'd0);

    // Directed loopback transaction.
    r0 = n_rsp;
    send(IR_BREAK, 38'h2A_5A5A_5A5A, 38'h15_1234_5678);
    wait_rsp(r0 + 1, 1'b0);
    chk("dir_rsp", 64'(rsp_data), 64'h15_1234_5678);
    chk("dir_latency", 64'(rsp_cyc - hs_cyc), 64'd165);
    chk("dir_tdi_stream", 64'(slave_sr), 64'h2A_5A5A_5A5A);

    // cmd_valid pulsed mid-transaction must be ignored.
    a0 = n_acc; r0 = n_rsp;
    send(IR_TRACEMEM, 38'h01_0203_0405, 38'h3F_0000_FFFF);
    repeat (40) @(posedge clk);
    #1 cmd_valid = 1'b1; cmd_data = 38'h00_DEAD_BEEF;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_rsp(r0 + 1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("pulse_acc", 64'(n_acc - a0), 64'd1);
    chk("pulse_rsp", 64'(rsp_data), 64'h3F_0000_FFFF);

    // Back-to-back with cmd_valid held.
    a0 = n_acc; r0 = n_rsp;
    d1 = SRW'({$urandom, $urandom}); c1 = SRW'({$urandom, $urandom});
    d2 = SRW'({$urandom, $urandom}); c2 = SRW'({$urandom, $urandom});
    cmd_ir = IR_TRACECTRL; cmd_data = d1; slave_cap = c1; cmd_valid = 1'b1;
    wait_acc(a0 + 1);
    cmd_ir = IR_BREAK; cmd_data = d2; slave_cap = c2;
    wait_acc(a0 + 2);
    chk("b2b_gap", 64'(hs_cyc - rsp_cyc), 64'd1);
    chk("b2b_rsp1", 64'(rsp_data), 64'(c1));
    cmd_valid = 1'b0;
    wait_rsp(r0 + 2, 1'b0);
    chk("b2b_rsp2", 64'(rsp_data), 64'(c2));

    // Reset during SDR bit 17.
    r0 = n_rsp;
    send(IR_OCIMEM, SRW'({$urandom, $urandom}), SRW'({$urandom, $urandom}));
    repeat ((2 + 17) * PER) @(posedge clk);
    #1 reset = 1'b1;
    #2;
    chk("rst_mid_tck", 64'(vji_tck), 64'd0);
    chk("rst_mid_rdy", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_norsp", 64'(n_rsp - r0), 64'd0);
    send(IR_TRACEMEM, 38'h2B_CAFE_F00D, 38'h12_3456_789A);
    wait_rsp(r0 + 1, 1'b0);
    chk("rst_mid_after", 64'(rsp_data), 64'h12_3456_789A);

    // IR cache sequence: fresh reset, then 00, 00, 01.
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    r0 = n_rsp; u0 = uir_cyc;
    send(IR_OCIMEM, 38'h11_1111_1111, 38'h22_2222_2222);
    wait_rsp(r0 + 1, 1'b0);
    chk("cache1_lat", 64'(rsp_cyc - hs_cyc), 64'd165);
    chk("cache1_uir", 64'(uir_cyc - u0), 64'(PER));
    u0 = uir_cyc;
    send(IR_OCIMEM, 38'h33_3333_3333, 38'h0C_CCCC_CCCC);
    wait_rsp(r0 + 2, 1'b0);
    chk("cache2_lat", 64'(rsp_cyc - hs_cyc), CACHE ? 64'd161 : 64'd165);
    chk("cache2_uir", 64'(uir_cyc - u0), CACHE ? 64'd0 : 64'(PER));
    chk("cache2_rsp", 64'(rsp_data), 64'h0C_CCCC_CCCC);
    u0 = uir_cyc;
    send(IR_TRACEMEM, 38'h05_5555_5555, 38'h0A_AAAA_AAAA);
    wait_rsp(r0 + 3, 1'b0);
    chk("cache3_lat", 64'(rsp_cyc - hs_cyc), 64'd165);
    chk("cache3_uir", 64'(uir_cyc - u0), 64'(PER));

    // Randomised commands with noise on cmd_valid while busy.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      r0 = n_rsp;
      c1 = SRW'({$urandom, $urandom});
      send(IRW'($urandom), SRW'({$urandom, $urandom}), c1);
      wait_rsp(r0 + 1, 1'b1);
      chk("rand_rsp", 64'(rsp_data), 64'(c1));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("rsp_count", 64'(dut_rsp_cnt), 64'(n_acc - n_abort));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
